// File: rtl/alu_exec.sv
// alu_exec: integer execution unit fed by the reservation-station issue port.
// Two-stage pipeline: stage 1 captures the issued op, stage 2 computes and
// drives the ALU common data bus (CDB) plus branch/jump resolution.
// Ports:
//   clk, rst (sync, active-high), rdy (global enable, low = hold all state)
//   in_rs_*      issued op, operands, immediate, destination tag, PC
//   in_rob_xbp   misbranch flush from the ROB, squashes all in-flight work
//   out_cdb_*    result tag (0 = idle), value, jump taken, redirect target
//   out_busy     stage 1 or stage 2 holds a valid op
module alu_exec #(
    parameter int ROB_POS_W = 4,
    parameter int OP_W      = 6,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic [OP_W-1:0]      in_rs_op,
    input  logic [XLEN-1:0]      in_rs_value1,
    input  logic [XLEN-1:0]      in_rs_value2,
    input  logic [XLEN-1:0]      in_rs_imm,
    input  logic [ROB_POS_W-1:0] in_rs_rob_pos,
    input  logic [XLEN-1:0]      in_rs_pc,
    input  logic                 in_rob_xbp,
    output logic [ROB_POS_W-1:0] out_cdb_pos,
    output logic [XLEN-1:0]      out_cdb_value,
    output logic                 out_cdb_jump,
    output logic [XLEN-1:0]      out_cdb_target,
    output logic                 out_busy
);

    // OPENUM encoding shared with the decoder / reservation station.
    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(12);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(13);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(15);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(16);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(17);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(18);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(19);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(20);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(21);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(22);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(23);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(24);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(25);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(26);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(27);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(28);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(29);

    // Shared ALU. Function codes follow the R-type op order so that
    // (op - OP_ADD) selects the function directly for register ops.
    function automatic logic [XLEN-1:0] alu_f(input logic [3:0] fn,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [4:0] shamt;
        shamt = b[4:0];
        case (fn)
            4'd0:    alu_f = a + b;
            4'd1:    alu_f = a - b;
            4'd2:    alu_f = a << shamt;
            4'd3:    alu_f = XLEN'($signed(a) < $signed(b));
            4'd4:    alu_f = XLEN'(a < b);
            4'd5:    alu_f = a ^ b;
            4'd6:    alu_f = a >> shamt;
            4'd7:    alu_f = $unsigned($signed(a) >>> shamt);
            4'd8:    alu_f = a | b;
            4'd9:    alu_f = a & b;
            default: alu_f = {XLEN{1'b0}};
        endcase
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic [OP_W-1:0]      s1_op_q, s1_op_d;
    logic [XLEN-1:0]      s1_v1_q, s1_v1_d;
    logic [XLEN-1:0]      s1_v2_q, s1_v2_d;
    logic [XLEN-1:0]      s1_imm_q, s1_imm_d;
    logic [ROB_POS_W-1:0] s1_pos_q, s1_pos_d;
    logic [XLEN-1:0]      s1_pc_q, s1_pc_d;

    logic [ROB_POS_W-1:0] cdb_pos_q, cdb_pos_d;
    logic [XLEN-1:0]      cdb_value_q, cdb_value_d;
    logic                 cdb_jump_q, cdb_jump_d;
    logic [XLEN-1:0]      cdb_target_q, cdb_target_d;

    logic [XLEN-1:0]      res_value_s;
    logic                 res_jump_s;
    logic [XLEN-1:0]      res_target_s;
    logic                 in_valid_s;

    assign in_valid_s = (in_rs_op != OP_NOP) && (in_rs_rob_pos != ROB_POS_W'(0));

    // Compute result of the op held in stage 1.
    always_comb begin
        res_value_s  = {XLEN{1'b0}};
        res_jump_s   = 1'b0;
        res_target_s = s1_pc_q + s1_imm_q;
        case (s1_op_q)
            OP_LUI:   res_value_s = s1_imm_q;
            OP_AUIPC: res_value_s = s1_pc_q + s1_imm_q;
            OP_JAL: begin
                res_value_s = s1_pc_q + XLEN'(4);
                res_jump_s  = 1'b1;
            end
            OP_JALR: begin
                res_value_s  = s1_pc_q + XLEN'(4);
                res_target_s = (s1_v1_q + s1_imm_q) & ~XLEN'(1);
                res_jump_s   = 1'b1;
            end
            OP_BEQ:   res_jump_s = (s1_v1_q == s1_v2_q);
            OP_BNE:   res_jump_s = (s1_v1_q != s1_v2_q);
            OP_BLT:   res_jump_s = ($signed(s1_v1_q) < $signed(s1_v2_q));
            OP_BGE:   res_jump_s = ($signed(s1_v1_q) >= $signed(s1_v2_q));
            OP_BLTU:  res_jump_s = (s1_v1_q < s1_v2_q);
            OP_BGEU:  res_jump_s = (s1_v1_q >= s1_v2_q);
            OP_ADDI:  res_value_s = alu_f(4'd0, s1_v1_q, s1_imm_q);
            OP_SLTI:  res_value_s = alu_f(4'd3, s1_v1_q, s1_imm_q);
            OP_SLTIU: res_value_s = alu_f(4'd4, s1_v1_q, s1_imm_q);
            OP_XORI:  res_value_s = alu_f(4'd5, s1_v1_q, s1_imm_q);
            OP_ORI:   res_value_s = alu_f(4'd8, s1_v1_q, s1_imm_q);
            OP_ANDI:  res_value_s = alu_f(4'd9, s1_v1_q, s1_imm_q);
            OP_SLLI:  res_value_s = alu_f(4'd2, s1_v1_q, s1_imm_q);
            OP_SRLI:  res_value_s = alu_f(4'd6, s1_v1_q, s1_imm_q);
            OP_SRAI:  res_value_s = alu_f(4'd7, s1_v1_q, s1_imm_q);
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
            OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND:
                res_value_s = alu_f(4'(s1_op_q - OP_ADD), s1_v1_q, s1_v2_q);
            // Unexpected ops still broadcast their tag with a zero result.
            default: res_value_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state for both pipeline stages; everything holds while rdy is low.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_op_d      = s1_op_q;
        s1_v1_d      = s1_v1_q;
        s1_v2_d      = s1_v2_q;
        s1_imm_d     = s1_imm_q;
        s1_pos_d     = s1_pos_q;
        s1_pc_d      = s1_pc_q;
        cdb_pos_d    = cdb_pos_q;
        cdb_value_d  = cdb_value_q;
        cdb_jump_d   = cdb_jump_q;
        cdb_target_d = cdb_target_q;
        if (!rdy) begin
            s1_valid_d = s1_valid_q;
        end else if (in_rob_xbp) begin
            // Flush squashes stage 1 and this cycle's issue; value/target hold.
            s1_valid_d = 1'b0;
            cdb_pos_d  = ROB_POS_W'(0);
            cdb_jump_d = 1'b0;
        end else begin
            s1_valid_d = in_valid_s;
            if (in_valid_s) begin
                s1_op_d  = in_rs_op;
                s1_v1_d  = in_rs_value1;
                s1_v2_d  = in_rs_value2;
                s1_imm_d = in_rs_imm;
                s1_pos_d = in_rs_rob_pos;
                s1_pc_d  = in_rs_pc;
            end else begin
                s1_op_d = s1_op_q;
            end
            if (s1_valid_q) begin
                cdb_pos_d    = s1_pos_q;
                cdb_value_d  = res_value_s;
                cdb_jump_d   = res_jump_s;
                cdb_target_d = res_target_s;
            end else begin
                cdb_pos_d  = ROB_POS_W'(0);
                cdb_jump_d = 1'b0;
            end
        end
    end

    // Pipeline registers with synchronous reset dominating rdy and flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= OP_NOP;
            s1_v1_q      <= {XLEN{1'b0}};
            s1_v2_q      <= {XLEN{1'b0}};
            s1_imm_q     <= {XLEN{1'b0}};
            s1_pos_q     <= ROB_POS_W'(0);
            s1_pc_q      <= {XLEN{1'b0}};
            cdb_pos_q    <= ROB_POS_W'(0);
            cdb_value_q  <= {XLEN{1'b0}};
            cdb_jump_q   <= 1'b0;
            cdb_target_q <= {XLEN{1'b0}};
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_v1_q      <= s1_v1_d;
            s1_v2_q      <= s1_v2_d;
            s1_imm_q     <= s1_imm_d;
            s1_pos_q     <= s1_pos_d;
            s1_pc_q      <= s1_pc_d;
            cdb_pos_q    <= cdb_pos_d;
            cdb_value_q  <= cdb_value_d;
            cdb_jump_q   <= cdb_jump_d;
            cdb_target_q <= cdb_target_d;
        end
    end

    assign out_cdb_pos    = cdb_pos_q;
    assign out_cdb_value  = cdb_value_q;
    assign out_cdb_jump   = cdb_jump_q;
    assign out_cdb_target = cdb_target_q;
    assign out_busy       = s1_valid_q | (cdb_pos_q != ROB_POS_W'(0));

endmodule
